// File: rtl/morph_pkg.sv
// Shared types and helpers for the 3x3 window scan controller.
package morph_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bit positions inside the {top, bottom, left, right} border flag vector.
  localparam int unsigned BORD_TOP   = 3;
  localparam int unsigned BORD_BOT   = 2;
  localparam int unsigned BORD_LEFT  = 1;
  localparam int unsigned BORD_RIGHT = 0;

  // Distance from the newest shifted pixel to the 3x3 window centre.
  function automatic int unsigned win_lat(input int unsigned img_w);
    return img_w + 1;
  endfunction

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Source, line-buffer and window-side signals of the window scan controller.
interface window_scan_ctrl_if #(
  parameter int unsigned CW = 16
);
  logic          start;
  logic          in_valid;
  logic [7:0]    in_pixel;
  logic          in_ready;
  logic          lb_en;
  logic [7:0]    lb_pixel;
  logic          win_valid;
  logic          out_ready;
  logic [CW-1:0] ctr_x;
  logic [CW-1:0] ctr_y;
  logic [3:0]    bord;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid, in_pixel, out_ready,
    input  in_ready, lb_en, lb_pixel, win_valid, ctr_x, ctr_y, bord, busy, done
  );

  modport slave (
    input  start, in_valid, in_pixel, out_ready,
    output in_ready, lb_en, lb_pixel, win_valid, ctr_x, ctr_y, bord, busy, done
  );
endinterface

// File: rtl/raster_counter.sv
// Raster-order (x, y) position counter over a W x H frame with wrap at the last pixel.
module raster_counter #(
  parameter int unsigned W  = 4,
  parameter int unsigned H  = 4,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  localparam logic [CW-1:0] X_MAX = CW'(W - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(H - 1);

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          x_end, y_end;

  assign x_end = (x_q == X_MAX);
  assign y_end = (y_q == Y_MAX);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end & y_end;

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame sequencer for the 3x3 line-buffer window stage: feeds pixels, pads the
// frame tail with zeros and tags each window with centre coordinates and borders.
module window_scan_ctrl
  import morph_pkg::*;
#(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256,
  parameter int unsigned CW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  window_scan_ctrl_if.slave bus
);

  localparam int unsigned N   = IMG_W * IMG_H;
  localparam int unsigned LAT = win_lat(IMG_W);
  localparam int unsigned SW  = $clog2(N + LAT + 1);
  localparam int unsigned PW  = $clog2(LAT + 1);

  localparam logic [SW-1:0] S_FIRST  = SW'(LAT + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(N + LAT);
  localparam logic [PW-1:0] PAD_LAST = PW'(LAT - 1);

  state_e        state_q, state_d;
  logic          win_valid_q, win_valid_d;
  logic          done_q, done_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [PW-1:0] pad_q, pad_d;

  logic          adv, accept, shift, consume, frame_go;
  logic [SW-1:0] shift_nxt;
  logic          in_last, ctr_last;
  logic [CW-1:0] in_x, in_y, ctr_x, ctr_y;

  // Handshake decode; a stalled window freezes the whole pipeline.
  always_comb begin
    adv          = bus.out_ready | ~win_valid_q;
    bus.in_ready = 1'b0;
    bus.lb_en    = 1'b0;
    bus.lb_pixel = '0;
    unique case (state_q)
      RUN: begin
        bus.in_ready = adv;
        bus.lb_en    = bus.in_valid & adv;
        bus.lb_pixel = bus.in_pixel;
      end
      FLUSH:   bus.lb_en = adv;
      default: ;
    endcase
  end

  assign accept    = bus.in_valid & bus.in_ready;
  assign shift     = bus.lb_en;
  assign consume   = win_valid_q & bus.out_ready;
  assign frame_go  = (state_q == IDLE) & bus.start;
  assign shift_nxt = shift_q + SW'(1);

  always_comb begin
    state_d     = state_q;
    win_valid_d = win_valid_q;
    done_d      = 1'b0;
    shift_d     = shift_q;
    pad_d       = pad_q;

    if (consume) win_valid_d = 1'b0;
    // A shift only yields a window once the centre has entered the frame.
    if (shift) begin
      shift_d = shift_nxt;
      if ((shift_nxt >= S_FIRST) && (shift_nxt <= S_LAST)) win_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN;
          shift_d     = '0;
          pad_d       = '0;
          win_valid_d = 1'b0;
        end
      end
      RUN: begin
        if (accept && in_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (shift) begin
          pad_d = pad_q + PW'(1);
          if (pad_q == PAD_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (consume && ctr_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
      shift_q     <= '0;
      pad_q       <= '0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      done_q      <= done_d;
      shift_q     <= shift_d;
      pad_q       <= pad_d;
    end
  end

  raster_counter #(.W(IMG_W), .H(IMG_H), .CW(CW)) u_in_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (frame_go),
    .inc   (accept),
    .x     (in_x),
    .y     (in_y),
    .last  (in_last)
  );

  raster_counter #(.W(IMG_W), .H(IMG_H), .CW(CW)) u_ctr_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (frame_go),
    .inc   (consume),
    .x     (ctr_x),
    .y     (ctr_y),
    .last  (ctr_last)
  );

  // Only the end-of-frame flag of the input position drives control.
  logic unused_in_pos;
  assign unused_in_pos = ^{in_x, in_y};

  always_comb begin
    bus.bord             = '0;
    bus.bord[BORD_TOP]   = (ctr_y == '0);
    bus.bord[BORD_BOT]   = (ctr_y == CW'(IMG_H - 1));
    bus.bord[BORD_LEFT]  = (ctr_x == '0);
    bus.bord[BORD_RIGHT] = (ctr_x == CW'(IMG_W - 1));
  end

  assign bus.ctr_x     = ctr_x;
  assign bus.ctr_y     = ctr_y;
  assign bus.win_valid = win_valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl on a 4x3 frame against a count-based model.
module tb_window_scan_ctrl;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int N   = W * H;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;

  window_scan_ctrl_if #(.CW(16)) bus ();

  window_scan_ctrl #(.IMG_W(4), .IMG_H(3), .CW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  // Model: frame progress expressed as counts of accepts, pads, windows made and consumed.
  bit m_act  = 0;
  bit m_done = 0;
  int m_a = 0, m_p = 0, m_prod = 0, m_c = 0;

  // Observed per-frame statistics.
  int o_acc, o_shift, t_start, t_done, t_acc6, t_wv1;
  bit seen_wv;
  int o_cx[$];
  int o_cy[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic int phase();
    if (!m_act) return 0;
    if (m_a < N) return 1;
    if (m_p < LAT) return 2;
    return 3;
  endfunction

  task automatic begin_frame(input int t);
    o_acc = 0; o_shift = 0; t_start = t; t_done = -1;
    t_acc6 = -100; t_wv1 = -200; seen_wv = 0;
    o_cx.delete(); o_cy.delete();
  endtask

  task automatic cyc(input bit rst, input bit st, input bit iv, input bit ordy, input logic [7:0] px);
    int ph, cidx, cx, cy, s;
    logic e_wv, e_adv, e_ir, e_lb;
    logic [7:0] e_px;
    logic [3:0] e_bord;
    rst_n         = ~rst;
    bus.start     = st;
    bus.in_valid  = iv;
    bus.in_pixel  = px;
    bus.out_ready = ordy;
    #2;
    ph    = phase();
    e_wv  = (m_prod > m_c);
    e_adv = ordy | ~e_wv;
    e_ir  = (ph == 1) & e_adv;
    e_lb  = (ph == 1) ? (iv & e_adv) : (ph == 2) ? e_adv : 1'b0;
    e_px  = (ph == 1) ? px : 8'h00;
    cidx  = m_c % N;
    cx    = cidx % W;
    cy    = cidx / W;
    e_bord = {cy == 0, cy == H - 1, cx == 0, cx == W - 1};
    chk("in_ready",  bus.in_ready,  e_ir);
    chk("lb_en",     bus.lb_en,     e_lb);
    chk("lb_pixel",  bus.lb_pixel,  e_px);
    chk("win_valid", bus.win_valid, e_wv);
    chk("ctr_x",     bus.ctr_x,     cx);
    chk("ctr_y",     bus.ctr_y,     cy);
    chk("bord",      bus.bord,      e_bord);
    chk("busy",      bus.busy,      ph != 0);
    chk("done",      bus.done,      m_done);
    if (bus.lb_en === 1'b1) o_shift++;
    if ((bus.in_valid & bus.in_ready) === 1'b1) begin
      o_acc++;
      if (o_acc == LAT + 1) t_acc6 = cyc_n;
    end
    if (bus.win_valid === 1'b1 && !seen_wv) begin
      seen_wv = 1;
      t_wv1   = cyc_n;
    end
    if ((bus.win_valid & bus.out_ready) === 1'b1) begin
      o_cx.push_back(int'(bus.ctr_x));
      o_cy.push_back(int'(bus.ctr_y));
    end
    if (bus.done === 1'b1) t_done = cyc_n;
    @(posedge clk);
    cyc_n++;
    if (rst) begin
      m_act = 0; m_done = 0; m_a = 0; m_p = 0; m_prod = 0; m_c = 0;
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (st) begin
          m_act = 1; m_a = 0; m_p = 0; m_prod = 0; m_c = 0;
        end
      end else begin
        if (e_wv && ordy) m_c++;
        if (e_lb) begin
          if (ph == 1) m_a++;
          else m_p++;
        end
        s = m_a + m_p;
        if (s > N + LAT) s = N + LAT;
        m_prod = (s > LAT) ? s - LAT : 0;
        if (ph == 3 && m_c == N) begin
          m_act  = 0;
          m_done = 1;
        end
      end
    end
    #1;
  endtask

  task automatic frame_check(input int exp_lat);
    chk("accepts", o_acc, N);
    chk("shifts", o_shift, N + LAT);
    chk("windows", o_cx.size(), N);
    for (int i = 0; i < o_cx.size() && i < N; i++) begin
      chk("win_x", o_cx[i], i % W);
      chk("win_y", o_cy[i], i / W);
    end
    chk("first_wv_lag", t_wv1 - t_acc6, 1);
    if (exp_lat > 0) chk("done_latency", t_done - t_start, exp_lat);
  endtask

  // mode 0: clean, 1: out_ready stall + stray start, 2: in_valid gaps, 3: both random.
  task automatic run_frame(input int mode, input bit b2b, input int exp_lat);
    int rel;
    bit iv, ordy;
    logic [7:0] px;
    rel = 0;
    if (!m_act) begin
      begin_frame(cyc_n);
      cyc(0, 1, 0, 1, 8'h00);
    end
    while (m_act && rel < 300) begin
      iv   = 1;
      ordy = 1;
      if (mode == 1 && rel >= 8 && rel <= 10) ordy = 0;
      if (mode == 2 || mode == 3) iv = ($urandom_range(0, 3) != 0);
      if (mode == 3) ordy = ($urandom_range(0, 2) != 0);
      px = (mode == 0) ? 8'(m_a + 1) : 8'($urandom);
      cyc(0, (mode == 1 && rel == 4), iv, ordy, px);
      rel++;
    end
    chk("frame_timeout", m_act, 0);
    cyc(0, b2b, 1, 1, 8'($urandom));
    frame_check(exp_lat);
    if (b2b) begin_frame(cyc_n - 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_pixel = '0; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 1, 8'h00);
    cyc(0, 0, 1, 1, 8'h55);
    cyc(0, 0, 1, 0, 8'hAA);

    run_frame(0, 0, N + LAT + 2);
    run_frame(1, 0, N + LAT + 2 + 3);
    run_frame(2, 0, 0);
    run_frame(3, 1, 0);
    run_frame(0, 0, N + LAT + 2);

    // Reset asserted while the 7th pixel is presented.
    begin_frame(cyc_n);
    cyc(0, 1, 0, 1, 8'h00);
    for (int k = 0; k < 20 && m_a < 6; k++) cyc(0, 0, 1, 1, 8'(m_a + 1));
    cyc(1, 0, 1, 1, 8'd7);
    cyc(0, 0, 1, 1, 8'd8);
    cyc(0, 0, 1, 1, 8'd9);
    chk("no_done_after_reset", t_done, -1);
    run_frame(0, 0, N + LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Frame sequencer for the 3x3 line-buffer window stage of the morphology pipeline. It accepts one raster-ordered 8-bit frame per `start`, drives the line buffer's shift/data inputs, and injects zero padding at end of frame so every pixel gets a window. It also tags each valid window with its centre coordinates and border flags. It sits between the pixel source and the line buffer plus the erode/dilate kernels, with valid/ready back-pressure on both sides.

## Interface
- `IMG_W`, 256: pixels per row; must be at least 3.
- `IMG_H`, 256: rows per frame; must be at least 3.
- `CW`, 16: width of the coordinate outputs.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle frame start pulse; sampled only in IDLE.
- `in_valid` in 1: source pixel valid.
- `in_pixel` in 8: source pixel.
- `in_ready` out 1: source pixel accepted when `in_valid & in_ready`.
- `lb_en` out 1: line-buffer shift enable; the line buffer advances only on cycles where this is high.
- `lb_pixel` out 8: line-buffer input; equals `in_pixel` in RUN and 0 in FLUSH.
- `win_valid` out 1: line-buffer window outputs are valid this cycle.
- `out_ready` in 1: downstream consumes the window when `win_valid & out_ready`.
- `ctr_x` out CW: column of the window centre.
- `ctr_y` out CW: row of the window centre.
- `bord` out 4: border flags {top, bottom, left, right} for the centre pixel.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the frame's last window is consumed.

## Operation
- N = IMG_W*IMG_H. LAT = IMG_W+1 is the pipeline distance between the newest pixel and the window centre.
- States:
  - IDLE: transitions to RUN on `start`.
  - RUN: transitions to FLUSH when the N-th pixel is accepted.
  - FLUSH: transitions to DONE when the LAT-th pad shift occurs.
  - DONE: when the last window is consumed, pulses `done` and returns to IDLE.
- Advance: `adv = (out_ready | ~win_valid)`.
  - In RUN: `in_ready = adv` and `lb_en = in_valid & adv`.
  - In FLUSH: `in_ready = 0` and `lb_en = adv`.
  - In IDLE and DONE: `in_ready = 0` and `lb_en = 0`.
- Input counter: (in_x, in_y) raster counter, incremented on each accepted pixel. It wraps x at IMG_W-1, and y increments at the wrap.
- Pad counter: counts FLUSH shifts from 0 to LAT-1.
- Shift count: s is the total number of shifts this frame. After shift s (1-based), the window centre is raster index s-1-LAT. A window is valid for centre indices 0..N-1.
- Centre counter: (ctr_x, ctr_y) raster counter, advanced when a window is consumed. On `start` it is set to (0,0).
- Border flags: top = (ctr_y==0), bottom = (ctr_y==IMG_H-1), left = (ctr_x==0), right = (ctr_x==IMG_W-1). The flags are combinational from the centre counter.
- `start` is ignored in RUN, FLUSH and DONE. `in_valid` is ignored outside RUN.
- Reset values: state=IDLE, all counters 0, `win_valid`=0, `done`=0, `busy`=0. As a result, `in_ready`=0, `lb_en`=0, `lb_pixel`=0, `ctr_x`=0, `ctr_y`=0 and `bord`=4'b1010.
- Reset mid-frame: the block returns to IDLE within one cycle and no `done` is issued. Line-buffer contents are not cleared by this block; padding and the centre counter make stale contents irrelevant.
- Stalls:
  - Window stalled (`win_valid & ~out_ready`): `lb_en`=0, and window, coordinates and `win_valid` are all held.
  - Source starved in RUN (`in_valid`=0): no shift. The pending `win_valid` drops once consumed; a window is never repeated.

## Timing
- `win_valid` is registered. It sets on the cycle after any shift whose count satisfies LAT+1 ≤ s ≤ N+LAT, so it aligns with the line-buffer outputs updated on that same edge.
- `win_valid` clears the cycle after consumption unless a qualifying shift occurred in the same cycle.
- First window: `win_valid` first rises on the cycle after the (LAT+1)-th accepted pixel.
- `done` is registered. It is high on the cycle after the N-th consumption, in the same cycle that state reads IDLE.
- `busy` falls in that same cycle.
- A `start` arriving in the cycle `done` is high is accepted, giving back-to-back frames.
- With `in_valid` and `out_ready` held high, a frame takes exactly 1 + N + LAT + 1 cycles from `start` to `done`.

## Structure
- Package `morph_pkg` holds:
  - the state encoding (2-bit enum IDLE/RUN/FLUSH/DONE);
  - the border-flag bit indices;
  - the function `win_lat(IMG_W)`, which returns IMG_W+1.
- Sub-module `raster_counter` (parameters W, H, CW; ports clr, inc, x, y, last) is instantiated twice: once for the input position and once for the window centre.
- The pad and shift counters are local.

## Test plan
- IMG_W=4, IMG_H=3, pixels 1..12, `in_valid` and `out_ready` always high:
  - first `win_valid` appears 1 cycle after the 6th accept;
  - exactly 12 windows are produced, with centres (0,0)..(3,2) in raster order;
  - 5 FLUSH shifts occur with `lb_pixel`=0;
  - `done` fires 19 cycles after `start`.
- Same frame, checking border flags: at centre (0,0) `bord`=1010; at (3,2) `bord`=0101; at (1,1) `bord`=0000.
- `out_ready` held low for 3 cycles mid-frame:
  - `lb_en`=0 and `in_ready`=0 throughout the stall;
  - window and coordinates stable;
  - no window lost or duplicated (12 total).
- `in_valid` gaps at random: shift count equals accept count, and the window sequence is identical to the no-gap run.
- `rst_n` low for 1 cycle during pixel 7: the next cycle shows IDLE, `busy`=0, `in_ready`=0, and no `done`. A following `start` yields a clean 12-window frame.
- `start` pulsed during RUN is ignored. `start` coincident with `done` runs a second frame immediately, and its coordinates restart at (0,0).
